predecode_fetch_queue: RTL and testbench
========================================

PREDECODE_FETCH_QUEUE -- requirements
Module: predecode_fetch_queue

Interface
REQ-001 SHALL have parameter XLEN, default 64, datapath width of PC, immediate and exception cause.
REQ-002 SHALL have parameter DEPTH, default 4, number of queue entries; power of two, at least 2.
REQ-003 SHALL have parameter INST_SIZE, default 32, instruction width.
REQ-004 SHALL use one clock and an asynchronous, active-low reset, with ports clk_i and rstn_i.
REQ-005 SHALL have these ports:
- clk_i  in  1  clock
- rstn_i  in  1  asynchronous active-low reset
- flush_i  in  1  discard all entries
- valid_i  in  1  fetch entry offered
- ready_o  out  1  queue can accept
- pc_i  in  XLEN  PC of offered instruction
- instr_i  in  INST_SIZE  raw instruction
- valid_o  out  1  head entry valid
- ready_i  in  1  consumer takes head
- pc_o  out  XLEN  head PC
- instr_o  out  INST_SIZE  head instruction
- class_o  out  4  head opcode class
- imm_o  out  XLEN  head sign-extended immediate
- ex_cause_o  out  XLEN  head exception cause
- count_o  out  $clog2(DEPTH+1)  occupancy

Function
REQ-006 SHALL complete a push when valid_i && ready_o, and a pop when valid_o && ready_i.
REQ-007 SHALL set ready_o = (count < DEPTH), with no combinational path from ready_i or valid_i.
REQ-008 SHALL set valid_o = (count != 0).
REQ-009 SHALL make a pushed entry visible at the head no earlier than the cycle after the push (1-cycle minimum latency); bypass is not allowed.
REQ-010 SHALL predecode at push time and store the predecode result with the entry.
REQ-011 SHALL derive class from opcode bits [6:0]:
- LUI 0x37=0, AUIPC 0x17=1, JAL 0x6F=2, JALR 0x67=3, BRANCH 0x63=4
- LOAD 0x03=5, STORE 0x23=6, ALU_I 0x13=7, ALU 0x33=8, ALU_I_W 0x1B=9, ALU_W 0x3B=10
- FENCE 0x0F=11, SYSTEM 0x73=12, ATOMICS 0x2F=13
- LOAD_FP 0x07 / STORE_FP 0x27 / FP 0x53 = 14
- anything else = 15 (illegal)
REQ-012 SHALL form the immediate by type, sign-extended to XLEN:
- I-type (classes 3, 5, 7, 9, 12, LOAD_FP): instr[31:20]
- S-type (6, STORE_FP): {instr[31:25], instr[11:7]}
- B-type (4): {instr[31], instr[7], instr[30:25], instr[11:8], 0}
- U-type (0, 1): {instr[31:12], 12'b0}
- J-type (2): {instr[31], instr[19:12], instr[20], instr[30:21], 0}
- all other classes: 0
REQ-013 SHALL mark an entry illegal, force class 15 and set ex_cause 0x02 for any of:
- instr[1:0] != 2'b11
- instr == 0
- unlisted opcode
- BRANCH with func3 010 or 011
- LOAD with func3 111
- STORE with func3[2] = 1
REQ-014 SHALL set ex_cause to 0xFF (none) for legal entries.
REQ-015 SHALL allow a simultaneous push and pop; count is unchanged.
REQ-016 SHALL ignore a push when full, even if a pop occurs in the same cycle.
REQ-017 SHALL ignore a pop when empty.
REQ-018 SHALL let read and write pointers wrap modulo DEPTH.
REQ-019 SHALL deliver entries in strict FIFO order.
REQ-020 SHALL, on flush_i, set count and pointers to 0 at the next edge; a push or pop in the same cycle is discarded.
REQ-021 SHALL drive pc_o, instr_o, imm_o and class_o to 0 and ex_cause_o to 0xFF while the queue is empty.
REQ-022 SHALL hold head outputs stable while valid_o && !ready_i.

Reset
REQ-023 SHALL, on rstn_i low, asynchronously clear pointers and count and force valid_o=0, ready_o=1, count_o=0, empty-state data outputs per REQ-021; storage contents need not be cleared.
REQ-024 SHALL lose all in-flight entries when reset is asserted mid-operation; the first push after release appears as a normal 1-cycle-latency entry.

Verification
REQ-025 SHALL verify: push pc=0x1000, instr=0x00500093 (addi) -> next cycle valid_o=1, class_o=7, imm_o=5, ex_cause_o=0xFF, pc_o=0x1000.
REQ-026 SHALL verify: push 0xFE000EE3 (beq -4) -> class_o=4, imm_o=0xFFFF_FFFF_FFFF_FFFC; push 0x00000000 -> class_o=15, ex_cause_o=0x02.
REQ-027 SHALL verify: DEPTH=4, ready_i=0, 5 pushes -> ready_o=0 after the 4th, count_o=4, 5th dropped; then drain 4 in order, count_o=0.
REQ-028 SHALL verify: count_o=2 with push+pop in the same cycle -> count_o stays 2; pointer wrap exercised over 3*DEPTH transfers with no loss or reorder.
REQ-029 SHALL verify: count_o=3, flush_i=1 with valid_i=1 -> next cycle count_o=0, valid_o=0, ready_o=1.
REQ-030 SHALL verify: rstn_i asserted asynchronously mid-stream with count_o=2 -> valid_o=0 and count_o=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/predecode_fetch_queue_if.sv
// Fetch-side and decode-side handshake bundle for the predecode fetch queue.
interface predecode_fetch_queue_if #(
  parameter int unsigned XLEN      = 64,
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned INST_SIZE = 32
);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic                 flush_i;
  logic                 valid_i;
  logic                 ready_o;
  logic [XLEN-1:0]      pc_i;
  logic [INST_SIZE-1:0] instr_i;
  logic                 valid_o;
  logic                 ready_i;
  logic [XLEN-1:0]      pc_o;
  logic [INST_SIZE-1:0] instr_o;
  logic [3:0]           class_o;
  logic [XLEN-1:0]      imm_o;
  logic [XLEN-1:0]      ex_cause_o;
  logic [CW-1:0]        count_o;

  modport master (
    output flush_i, valid_i, pc_i, instr_i, ready_i,
    input  ready_o, valid_o, pc_o, instr_o, class_o, imm_o, ex_cause_o, count_o
  );

  modport slave (
    input  flush_i, valid_i, pc_i, instr_i, ready_i,
    output ready_o, valid_o, pc_o, instr_o, class_o, imm_o, ex_cause_o, count_o
  );
endinterface

// File: rtl/predecode_fetch_queue.sv
// Fetch queue that classifies each instruction and extracts its immediate on push,
// so the head entry carries ready-made predecode fields.
module predecode_fetch_queue #(
  parameter int unsigned XLEN      = 64,
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned INST_SIZE = 32
) (
  input logic                  clk_i,
  input logic                  rstn_i,
  predecode_fetch_queue_if.slave q
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  typedef enum logic [3:0] {
    CLS_LUI = 4'd0, CLS_AUIPC = 4'd1, CLS_JAL = 4'd2, CLS_JALR = 4'd3,
    CLS_BRANCH = 4'd4, CLS_LOAD = 4'd5, CLS_STORE = 4'd6, CLS_ALU_I = 4'd7,
    CLS_ALU = 4'd8, CLS_ALU_I_W = 4'd9, CLS_ALU_W = 4'd10, CLS_FENCE = 4'd11,
    CLS_SYSTEM = 4'd12, CLS_ATOMICS = 4'd13, CLS_FP = 4'd14, CLS_ILLEGAL = 4'd15
  } cls_e;

  typedef struct packed {
    logic [XLEN-1:0]      pc;
    logic [INST_SIZE-1:0] instr;
    cls_e                 cls;
    logic [XLEN-1:0]      imm;
    logic [XLEN-1:0]      ex;
  } entry_t;

  entry_t        mem_q [DEPTH];
  entry_t        pd, head;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          push, pop, illegal;
  logic [6:0]    opcode;
  logic [2:0]    f3;
  logic [31:0]   ins, imm_i, imm_s, imm_b, imm_u, imm_j, imm32;
  cls_e          cls;

  assign q.ready_o = (count_q < CW'(DEPTH));
  assign q.valid_o = (count_q != '0);
  assign push      = q.valid_i && q.ready_o;
  assign pop       = q.valid_o && q.ready_i;

  always_comb begin
    ins    = q.instr_i[31:0];
    opcode = ins[6:0];
    f3     = ins[14:12];
    imm_i  = {{20{ins[31]}}, ins[31:20]};
    imm_s  = {{20{ins[31]}}, ins[31:25], ins[11:7]};
    imm_b  = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
    imm_u  = {ins[31:12], 12'b0};
    imm_j  = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
    cls    = CLS_ILLEGAL;
    imm32  = '0;
    case (opcode)
      7'h37: begin cls = CLS_LUI;     imm32 = imm_u; end
      7'h17: begin cls = CLS_AUIPC;   imm32 = imm_u; end
      7'h6F: begin cls = CLS_JAL;     imm32 = imm_j; end
      7'h67: begin cls = CLS_JALR;    imm32 = imm_i; end
      7'h63: begin cls = CLS_BRANCH;  imm32 = imm_b; end
      7'h03: begin cls = CLS_LOAD;    imm32 = imm_i; end
      7'h23: begin cls = CLS_STORE;   imm32 = imm_s; end
      7'h13: begin cls = CLS_ALU_I;   imm32 = imm_i; end
      7'h33:       cls = CLS_ALU;
      7'h1B: begin cls = CLS_ALU_I_W; imm32 = imm_i; end
      7'h3B:       cls = CLS_ALU_W;
      7'h0F:       cls = CLS_FENCE;
      7'h73: begin cls = CLS_SYSTEM;  imm32 = imm_i; end
      7'h2F:       cls = CLS_ATOMICS;
      7'h07: begin cls = CLS_FP;      imm32 = imm_i; end
      7'h27: begin cls = CLS_FP;      imm32 = imm_s; end
      7'h53:       cls = CLS_FP;
      default:     cls = CLS_ILLEGAL;
    endcase
    illegal = (ins[1:0] != 2'b11) || (q.instr_i == '0) || (cls == CLS_ILLEGAL) ||
              (cls == CLS_BRANCH && f3[2:1] == 2'b01) ||
              (cls == CLS_LOAD && f3 == 3'b111) ||
              (cls == CLS_STORE && f3[2]);
    pd.pc    = q.pc_i;
    pd.instr = q.instr_i;
    pd.cls   = illegal ? CLS_ILLEGAL : cls;
    pd.imm   = illegal ? '0 : XLEN'($signed(imm32));
    pd.ex    = illegal ? XLEN'(8'h02) : XLEN'(8'hFF);
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (q.flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      if (push && !pop)      count_d = count_q + CW'(1);
      else if (pop && !push) count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is not reset; validity comes solely from count_q.
  always_ff @(posedge clk_i) begin
    if (push && !q.flush_i) mem_q[wr_ptr_q] <= pd;
  end

  always_comb begin
    head         = mem_q[rd_ptr_q];
    q.pc_o       = '0;
    q.instr_o    = '0;
    q.class_o    = '0;
    q.imm_o      = '0;
    q.ex_cause_o = XLEN'(8'hFF);
    if (q.valid_o) begin
      q.pc_o       = head.pc;
      q.instr_o    = head.instr;
      q.class_o    = head.cls;
      q.imm_o      = head.imm;
      q.ex_cause_o = head.ex;
    end
  end

  assign q.count_o = count_q;
endmodule

// File: tb/tb_predecode_fetch_queue.sv
// Randomized and directed checks of the predecode fetch queue against a queue-based model.
module tb_predecode_fetch_queue;
  localparam int unsigned XLEN  = 64;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned ISZ   = 32;

  typedef struct {
    logic [63:0] pc;
    logic [31:0] ins;
    logic [63:0] cls;
    logic [63:0] imm;
    logic [63:0] ex;
  } entry_t;

  logic   clk = 1'b0;
  logic   rstn;
  int     n_checks = 0;
  int     n_errors = 0;
  entry_t mdl[$];

  always #5 clk = ~clk;

  predecode_fetch_queue_if #(.XLEN(XLEN), .DEPTH(DEPTH), .INST_SIZE(ISZ)) bus ();

  predecode_fetch_queue #(.XLEN(XLEN), .DEPTH(DEPTH), .INST_SIZE(ISZ)) dut (
    .clk_i (clk),
    .rstn_i(rstn),
    .q     (bus)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference predecode: arithmetic on a sign-extended word rather than bit concatenation.
  function automatic entry_t ref_decode(input logic [63:0] pc, input logic [31:0] ins);
    entry_t e;
    longint s;
    int     opc, f3;
    int     cls;
    string  fmt;
    bit     bad;
    s   = longint'($signed(ins));
    opc = int'(ins[6:0]);
    f3  = int'(ins[14:12]);
    fmt = "N";
    case (opc)
      'h37: begin cls = 0;  fmt = "U"; end
      'h17: begin cls = 1;  fmt = "U"; end
      'h6F: begin cls = 2;  fmt = "J"; end
      'h67: begin cls = 3;  fmt = "I"; end
      'h63: begin cls = 4;  fmt = "B"; end
      'h03: begin cls = 5;  fmt = "I"; end
      'h23: begin cls = 6;  fmt = "S"; end
      'h13: begin cls = 7;  fmt = "I"; end
      'h33: cls = 8;
      'h1B: begin cls = 9;  fmt = "I"; end
      'h3B: cls = 10;
      'h0F: cls = 11;
      'h73: begin cls = 12; fmt = "I"; end
      'h2F: cls = 13;
      'h07: begin cls = 14; fmt = "I"; end
      'h27: begin cls = 14; fmt = "S"; end
      'h53: cls = 14;
      default: cls = 15;
    endcase
    bad = (ins[1:0] != 2'b11) || (ins == 32'd0) || (cls == 15) ||
          (cls == 4 && (f3 == 2 || f3 == 3)) || (cls == 5 && f3 == 7) ||
          (cls == 6 && f3 >= 4);
    e.pc  = pc;
    e.ins = ins;
    if (bad) begin
      e.cls = 64'd15;
      e.imm = 64'd0;
      e.ex  = 64'h02;
    end else begin
      e.cls = 64'(cls);
      e.ex  = 64'hFF;
      case (fmt)
        "I": e.imm = s >>> 20;
        "U": e.imm = s & ~longint'(32'hFFF);
        "S": e.imm = ((s >>> 25) <<< 5) | longint'(ins[11:7]);
        "B": e.imm = ((s >>> 31) <<< 12) | (longint'(ins[7]) << 11) |
                     (longint'(ins[30:25]) << 5) | (longint'(ins[11:8]) << 1);
        "J": e.imm = ((s >>> 31) <<< 20) | (longint'(ins[19:12]) << 12) |
                     (longint'(ins[20]) << 11) | (longint'(ins[30:21]) << 1);
        default: e.imm = 0;
      endcase
    end
    return e;
  endfunction

  task automatic check_all();
    check("valid_o", 64'(bus.valid_o), 64'(mdl.size() != 0));
    check("ready_o", 64'(bus.ready_o), 64'(mdl.size() < DEPTH));
    check("count_o", 64'(bus.count_o), 64'(mdl.size()));
    if (mdl.size() != 0) begin
      check("pc_o",    bus.pc_o,           mdl[0].pc);
      check("instr_o", 64'(bus.instr_o),   64'(mdl[0].ins));
      check("class_o", 64'(bus.class_o),   mdl[0].cls);
      check("imm_o",   bus.imm_o,          mdl[0].imm);
      check("ex_o",    bus.ex_cause_o,     mdl[0].ex);
    end else begin
      check("pc_o_e",    bus.pc_o,         64'd0);
      check("instr_o_e", 64'(bus.instr_o), 64'd0);
      check("class_o_e", 64'(bus.class_o), 64'd0);
      check("imm_o_e",   bus.imm_o,        64'd0);
      check("ex_o_e",    bus.ex_cause_o,   64'hFF);
    end
  endtask

  task automatic cycle(input logic v, input logic [63:0] pc, input logic [31:0] ins,
                       input logic rdy, input logic fl);
    bit do_push, do_pop;
    bus.valid_i = v;
    bus.pc_i    = pc;
    bus.instr_i = ins;
    bus.ready_i = rdy;
    bus.flush_i = fl;
    @(posedge clk);
    if (fl) begin
      mdl.delete();
    end else begin
      do_pop  = (mdl.size() != 0) && rdy;
      do_push = v && (mdl.size() < DEPTH);
      if (do_pop) void'(mdl.pop_front());
      if (do_push) mdl.push_back(ref_decode(pc, ins));
    end
    #1;
    check_all();
  endtask

  function automatic logic [31:0] rand_instr();
    logic [6:0] ops [20];
    logic [31:0] r;
    ops = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h1B,
            7'h3B, 7'h0F, 7'h73, 7'h2F, 7'h07, 7'h27, 7'h53, 7'h7F, 7'h0B, 7'h12};
    r = $urandom;
    case ($urandom_range(0, 9))
      0:       return 32'd0;
      1:       return r;
      default: return {r[31:7], ops[$urandom_range(0, 19)]};
    endcase
  endfunction

  logic [63:0] pcn = 64'h8000_0000;

  task automatic rcycle(input int pv, input int pr);
    pcn = pcn + 64'd4;
    cycle(1'($urandom_range(0, 99) < pv), pcn, rand_instr(), 1'($urandom_range(0, 99) < pr), 1'b0);
  endtask

  initial begin
    rstn        = 1'b0;
    bus.valid_i = 1'b0;
    bus.ready_i = 1'b0;
    bus.flush_i = 1'b0;
    bus.pc_i    = '0;
    bus.instr_i = '0;
    #2;
    check_all();
    @(negedge clk);
    rstn = 1'b1;

    // addi x1, x0, 5
    cycle(1, 64'h1000, 32'h00500093, 0, 0);
    check("addi_valid", 64'(bus.valid_o), 64'd1);
    check("addi_class", 64'(bus.class_o), 64'd7);
    check("addi_imm",   bus.imm_o,        64'd5);
    check("addi_ex",    bus.ex_cause_o,   64'hFF);
    check("addi_pc",    bus.pc_o,         64'h1000);

    // beq -4, then an all-zero word
    cycle(1, 64'h1004, 32'hFE000EE3, 1, 0);
    check("beq_class", 64'(bus.class_o), 64'd4);
    check("beq_imm",   bus.imm_o,        64'hFFFF_FFFF_FFFF_FFFC);
    cycle(1, 64'h1008, 32'h00000000, 1, 0);
    check("zero_class", 64'(bus.class_o), 64'd15);
    check("zero_ex",    bus.ex_cause_o,   64'h02);
    cycle(0, 64'h0, 32'h0, 1, 0);
    check("drained", 64'(bus.count_o), 64'd0);

    // Fill past capacity with the consumer stalled
    for (int unsigned i = 0; i < 5; i++) begin
      cycle(1, 64'h2000 + 64'(4 * i), 32'h00100013 + (i << 20), 0, 0);
      if (i == 3) begin
        check("full_ready", 64'(bus.ready_o), 64'd0);
        check("full_count", 64'(bus.count_o), 64'd4);
      end
    end
    check("full_drop_count", 64'(bus.count_o), 64'd4);
    check("full_head_pc", bus.pc_o, 64'h2000);
    for (int unsigned i = 0; i < 4; i++) cycle(0, 64'h0, 32'h0, 1, 0);
    check("full_drain", 64'(bus.count_o), 64'd0);

    // Simultaneous push/pop at count 2, then wrap over 3*DEPTH transfers
    rcycle(100, 0);
    rcycle(100, 0);
    cycle(1, 64'h3000, 32'h00000037, 1, 0);
    check("pushpop_count", 64'(bus.count_o), 64'd2);
    for (int unsigned i = 0; i < 3 * DEPTH; i++) rcycle(100, 100);
    for (int unsigned i = 0; i < DEPTH; i++) rcycle(0, 100);

    // Flush at count 3 with a concurrent push
    for (int unsigned i = 0; i < 3; i++) rcycle(100, 0);
    check("pre_flush_count", 64'(bus.count_o), 64'd3);
    cycle(1, 64'h4000, 32'h00500093, 0, 1);
    check("flush_count", 64'(bus.count_o), 64'd0);
    check("flush_valid", 64'(bus.valid_o), 64'd0);
    check("flush_ready", 64'(bus.ready_o), 64'd1);

    // Asynchronous reset with two entries in flight
    rcycle(100, 0);
    rcycle(100, 0);
    check("pre_rst_count", 64'(bus.count_o), 64'd2);
    #2;
    rstn        = 1'b0;
    bus.valid_i = 1'b0;
    bus.ready_i = 1'b0;
    #1;
    check("arst_valid", 64'(bus.valid_o), 64'd0);
    check("arst_count", 64'(bus.count_o), 64'd0);
    check("arst_ready", 64'(bus.ready_o), 64'd1);
    mdl.delete();
    check_all();
    @(negedge clk);
    rstn = 1'b1;
    cycle(1, 64'h5000, 32'h00500093, 0, 0);
    check("post_rst_valid", 64'(bus.valid_o), 64'd1);
    check("post_rst_pc",    bus.pc_o,         64'h5000);

    // Random traffic with occasional flush
    for (int unsigned i = 0; i < 600; i++) begin
      pcn = pcn + 64'd4;
      cycle(1'($urandom_range(0, 99) < 60), pcn, rand_instr(),
            1'($urandom_range(0, 99) < 50), 1'($urandom_range(0, 31) == 0));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
